// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: RV32I fetch stage with PC, in-order imem requests, instruction buffer and redirect/halt handling.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_OUT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump_enable,
    input  logic [31:0] jump_addr,
    input  logic        halt,
    input  logic        id_ready,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic        if_valid,
    output logic        misaligned
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [31:0]     pc_q, pc_d, iw_q, iw_d;
    logic            valid_q, valid_d, mis_q, mis_d;
    logic [CW-1:0]   cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [63:0]     mem_q [FIFO_DEPTH];
    logic [31:0]     target;
    logic            run, halting, jump, accept, rsp, push, pop;

    always_comb begin
        run            = state_q == RUN;
        halting        = !run || halt;
        jump           = run && jump_enable;
        target         = {jump_addr[31:2], 2'b00};
        // Credits cover both in-flight requests and buffered words so the buffer cannot overflow.
        imem_req_valid = run && !reset && (out_q < CW'(MAX_OUT)) && (out_q + cnt_q < CW'(FIFO_DEPTH))
                         && !jump_enable && !halt;
        imem_addr      = fetch_pc_q;
        accept         = imem_req_valid && imem_req_ready;
        rsp            = imem_rsp_valid && out_q != '0;
        push           = rsp && drop_q == '0 && !halting && !jump;
        pop            = !jump && !halting && id_ready && cnt_q != '0;
        state_d        = (run && halt) ? HALT : state_q;
        out_d          = out_q + CW'(accept) - CW'(rsp);
        fetch_pc_d     = jump ? target : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d      = jump ? target : push ? resp_pc_q + 32'd4 : resp_pc_q;
        drop_d         = jump ? out_d : (rsp && drop_q != '0) ? drop_q - CW'(1) : drop_q;
        cnt_d          = jump ? '0 : cnt_q + CW'(push) - CW'(pop);
        wr_d           = jump ? '0 : wr_q + PW'(push);
        rd_d           = jump ? '0 : rd_q + PW'(pop);
        iw_d           = (jump || halting) ? NOP : pop ? mem_q[rd_q][31:0] : id_ready ? NOP : iw_q;
        valid_d        = (jump || halting) ? 1'b0 : pop ? 1'b1 : id_ready ? 1'b0 : valid_q;
        pc_d           = pop ? mem_q[rd_q][63:32] : pc_q;
        mis_d          = jump && |jump_addr[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            pc_q       <= RESET_PC;
            iw_q       <= NOP;
            valid_q    <= 1'b0;
            mis_q      <= 1'b0;
            cnt_q      <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            pc_q       <= pc_d;
            iw_q       <= iw_d;
            valid_q    <= valid_d;
            mis_q      <= mis_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {resp_pc_q, imem_rsp_data};
    end

    assign pc_out     = pc_q;
    assign iw_out     = iw_q;
    assign if_valid   = valid_q;
    assign misaligned = mis_q;
endmodule
